// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE256 types and constants for the absorb front end.
package keccak_pkg;

    typedef logic [63:0] lane_t;
    typedef lane_t [0:4][0:4] state_t;

    localparam int unsigned RATE_LANES = 17;
    localparam int unsigned RATE_BYTES = 136;

    localparam logic [7:0] PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {
        S_ABSORB,
        S_PERM,
        S_PAD,
        S_DONE
    } absorb_state_e;

endpackage

// File: rtl/shake_pad_lane.sv
// Byte-masks one message word and inserts SHAKE padding that falls inside that same lane.
module shake_pad_lane
    import keccak_pkg::*;
(
    input  lane_t      data,
    input  logic [3:0] bytes,
    input  logic       last,
    input  logic       lane_16,
    output lane_t      lane_xor,
    output logic       full,
    output logic       spill
);

    logic [3:0] eff;

    always_comb begin
        eff = 4'd8;
        if (last && (bytes < 4'd8)) begin
            eff = bytes;
        end

        lane_xor = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < eff) begin
                lane_xor[8*k +: 8] = data[8*k +: 8];
            end
        end

        full  = (eff == 4'd8);
        spill = 1'b0;
        if (last) begin
            if (!full) begin
                lane_xor[{eff[2:0], 3'b000} +: 8] = lane_xor[{eff[2:0], 3'b000} +: 8] ^ PAD_DOMAIN;
                if (lane_16) begin
                    lane_xor[63:56] = lane_xor[63:56] ^ PAD_FINAL;
                end
            end else begin
                // Full last word: domain byte lands in the next lane, unless the block is full.
                spill = !lane_16;
            end
        end
    end

endmodule

// File: rtl/shake256_absorb.sv
// SHAKE256 absorb stage: XORs message words into the rate, pads, and hands blocks to Keccak-f.
module shake256_absorb
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [63:0] msg_data,
    input  logic [3:0]  msg_bytes,
    input  logic        msg_last,
    output state_t      state_out,
    output logic        perm_start,
    input  logic        perm_done,
    input  state_t      state_in,
    output logic        absorb_done
);

    localparam int unsigned LastX = (RATE_LANES - 1) % 5;
    localparam int unsigned LastY = (RATE_LANES - 1) / 5;

    absorb_state_e st;
    state_t        state_q;
    state_t        absorbed;
    state_t        padded;
    logic [4:0]    lane_cnt;
    logic          final_q;
    logic          pad_pending;

    lane_t pad_lane;
    logic  lane_16;
    logic  word_full;
    logic  spill;
    logic  pad_now;

    assign lane_16 = (lane_cnt == 5'(RATE_LANES - 1));
    assign pad_now = msg_last && lane_16 && word_full;
    assign state_out = state_q;

    shake_pad_lane u_pad_lane (
        .data     (msg_data),
        .bytes    (msg_bytes),
        .last     (msg_last),
        .lane_16  (lane_16),
        .lane_xor (pad_lane),
        .full     (word_full),
        .spill    (spill)
    );

    always_comb begin
        absorbed = state_q;
        for (int i = 0; i < int'(RATE_LANES); i++) begin
            if (lane_cnt == 5'(i)) begin
                absorbed[i % 5][i / 5] = absorbed[i % 5][i / 5] ^ pad_lane;
            end
            if (spill && ((lane_cnt + 5'd1) == 5'(i))) begin
                absorbed[i % 5][i / 5] = absorbed[i % 5][i / 5] ^ {56'd0, PAD_DOMAIN};
            end
        end
        // Final pad bit for a last word sitting in an earlier lane.
        if (msg_last && !lane_16) begin
            absorbed[LastX][LastY] = absorbed[LastX][LastY] ^ {PAD_FINAL, 56'd0};
        end
    end

    always_comb begin
        padded = state_q;
        padded[0][0] = padded[0][0] ^ {56'd0, PAD_DOMAIN};
        padded[LastX][LastY] = padded[LastX][LastY] ^ {PAD_FINAL, 56'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_ABSORB;
            state_q     <= '0;
            lane_cnt    <= '0;
            final_q     <= 1'b0;
            pad_pending <= 1'b0;
            msg_ready   <= 1'b1;
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
        end else if (init && (st != S_PERM)) begin
            st          <= S_ABSORB;
            state_q     <= '0;
            lane_cnt    <= '0;
            final_q     <= 1'b0;
            pad_pending <= 1'b0;
            msg_ready   <= 1'b1;
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
        end else begin
            unique case (st)
                S_ABSORB: begin
                    if (msg_valid) begin
                        state_q  <= absorbed;
                        lane_cnt <= lane_cnt + 5'd1;
                        if (msg_last || lane_16) begin
                            st          <= S_PERM;
                            msg_ready   <= 1'b0;
                            perm_start  <= 1'b1;
                            final_q     <= msg_last && !pad_now;
                            pad_pending <= pad_now;
                        end
                    end
                end
                S_PERM: begin
                    perm_start <= 1'b0;
                    // perm_start high marks the first cycle, where perm_done is not trusted.
                    if (!perm_start && perm_done) begin
                        state_q  <= state_in;
                        lane_cnt <= '0;
                        if (final_q) begin
                            st          <= S_DONE;
                            absorb_done <= 1'b1;
                        end else if (pad_pending) begin
                            st <= S_PAD;
                        end else begin
                            st        <= S_ABSORB;
                            msg_ready <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    state_q     <= padded;
                    pad_pending <= 1'b0;
                    final_q     <= 1'b1;
                    st          <= S_PERM;
                    perm_start  <= 1'b1;
                end
                S_DONE: begin
                    absorb_done <= 1'b1;
                end
                default: begin
                    st <= S_ABSORB;
                end
            endcase
        end
    end

endmodule
